// File: rtl/seg_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seg_digit_scanner
// Brief    : Time-multiplexed 7-seg digit scanner with blanking gap and
//            frame-synchronous shadow load. Optional leading-zero blanking
//            when SEG_LZB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module seg_digit_scanner #(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 12500,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [4*NUM_DIGITS-1:0]   i_value,
    input  logic                      i_load,
    input  logic                      i_enable,
    output logic [3:0]                o_hex,
    output logic [NUM_DIGITS-1:0]     o_digit_en,
    output logic                      o_pending,
    output logic                      o_frame_start
);

    localparam int c_MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
    localparam int c_IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_CNT_W-1:0]    c_DWELL_LAST = c_CNT_W'(DWELL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]    c_BLANK_LAST = c_CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_ONE_HOT0   = NUM_DIGITS'(1);

    localparam logic [0:0] c_ST_BLANK = 1'b0;
    localparam logic [0:0] c_ST_SHOW  = 1'b1;

    logic [0:0]              r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_IDX_W-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_active;

    logic [0:0]              w_state_nxt;
    logic [c_CNT_W-1:0]      w_cnt_nxt;
    logic [c_IDX_W-1:0]      w_idx_nxt;
    logic                    w_wrap;
    logic                    w_enter_show;
    logic [4*NUM_DIGITS-1:0] w_active_nxt;
    logic                    w_lzb_ok;
    logic [NUM_DIGITS-1:0]   w_den_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_wrap       = 1'b0;
        w_enter_show = 1'b0;
        case (r_state)
            c_ST_BLANK: begin
                if ((BLANK_CYCLES == 0) || (r_cnt == c_BLANK_LAST)) begin
                    w_state_nxt  = c_ST_SHOW;
                    w_cnt_nxt    = '0;
                    w_enter_show = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_SHOW: begin
                if (r_cnt == c_DWELL_LAST) begin
                    w_cnt_nxt = '0;
                    w_wrap    = (r_idx == c_IDX_LAST);
                    w_idx_nxt = w_wrap ? '0 : r_idx + 1'b1;
                    // With no gap the next digit's SHOW follows directly.
                    if (BLANK_CYCLES == 0) begin
                        w_state_nxt  = c_ST_SHOW;
                        w_enter_show = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_BLANK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_BLANK;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the FSM.
    assign w_active_nxt = (w_wrap && o_pending) ? r_shadow : r_active;

`ifdef SEG_LZB_EN
    logic [NUM_DIGITS-1:0] w_lit_ok;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lzb
        if (k == 0) begin : g_d0
            assign w_lit_ok[k] = 1'b1;
        end else begin : g_dk
            assign w_lit_ok[k] = |w_active_nxt[4*NUM_DIGITS-1:4*k];
        end
    end

    assign w_lzb_ok = w_lit_ok[w_idx_nxt];
`else
    assign w_lzb_ok = 1'b1;
`endif

    assign w_den_nxt = (i_enable && (w_state_nxt == c_ST_SHOW) && w_lzb_ok)
                     ? (c_ONE_HOT0 << w_idx_nxt) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= c_ST_BLANK;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_active      <= '0;
            o_hex         <= '0;
            o_digit_en    <= '0;
            o_pending     <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_active      <= w_active_nxt;
            o_hex         <= w_active_nxt[{w_idx_nxt, 2'b00} +: 4];
            o_digit_en    <= w_den_nxt;
            o_frame_start <= w_enter_show && (w_idx_nxt == '0);
            if (i_load) begin
                r_shadow  <= i_value;
                o_pending <= 1'b1;
            end else if (w_wrap) begin
                o_pending <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_digit_scanner.sv
`default_nettype none
// Bench for seg_digit_scanner: two instances (gap of 2 and no gap) checked
// against a frame-arithmetic reference model.
module tb_seg_digit_scanner;

    localparam int ND = 2;
    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic       en = 1'b1;
    logic [7:0] value = 8'h00;

    logic [3:0] hex0, hex1;
    logic [1:0] den0, den1;
    logic       pend0, pend1, fs0, fs1;

    always #5 clk = ~clk;

    seg_digit_scanner #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(2)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_load(load), .i_enable(en),
        .o_hex(hex0), .o_digit_en(den0), .o_pending(pend0), .o_frame_start(fs0)
    );

    seg_digit_scanner #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(0)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_load(load), .i_enable(en),
        .o_hex(hex1), .o_digit_en(den1), .o_pending(pend1), .o_frame_start(fs1)
    );

    int checks = 0;
    int errors = 0;
    int t = 0;

    logic [7:0] m_act [2];
    logic [7:0] m_shd [2];
    logic       m_pend [2];
    logic       m_en;

    function automatic int blank_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    // With no gap the DUT spends its reset cycle in BLANK, delaying the frame by one clock.
    function automatic int offset_of(input int i);
        return (blank_of(i) == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s t=%0d got %h exp %h", tag, t, got, exp);
        end
    endtask

    task automatic reset_model();
        t = 0;
        m_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_act[i]  = 8'h00;
            m_shd[i]  = 8'h00;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int per, te;
            per = ND * (blank_of(i) + DW);
            te  = t - offset_of(i);
            if (te >= 0 && (te % per) == per - 1 && m_pend[i]) begin
                m_act[i]  = m_shd[i];
                m_pend[i] = 1'b0;
            end
            if (load) begin
                m_shd[i]  = value;
                m_pend[i] = 1'b1;
            end
        end
        m_en = en;
        t++;
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int per, slot, te, p, s, off;
            logic show, lit;
            logic [3:0] g_hex, e_hex;
            logic [1:0] g_den, e_den;
            logic g_fs, e_fs, g_pend;
            g_hex  = (i == 0) ? hex0 : hex1;
            g_den  = (i == 0) ? den0 : den1;
            g_fs   = (i == 0) ? fs0 : fs1;
            g_pend = (i == 0) ? pend0 : pend1;
            slot = blank_of(i) + DW;
            per  = ND * slot;
            te   = t - offset_of(i);
            if (te < 0) begin
                chk($sformatf("hex%0d_pre", i), {4'h0, g_hex}, 8'h00);
                chk($sformatf("den%0d_pre", i), {6'h0, g_den}, 8'h00);
                chk($sformatf("fs%0d_pre", i), {7'h0, g_fs}, 8'h00);
            end else begin
                p    = te % per;
                s    = p / slot;
                off  = p % slot;
                show = (off >= blank_of(i));
                e_hex = 4'((m_act[i] >> (4 * s)) & 8'h0F);
`ifdef SEG_LZB_EN
                lit = (s == 0) || ((m_act[i] >> (4 * s)) != 8'h00);
`else
                lit = 1'b1;
`endif
                e_den = (show && m_en && lit) ? 2'(1 << s) : 2'b00;
                e_fs  = show && (s == 0) && (off == blank_of(i));
                if (show) chk($sformatf("hex%0d", i), {4'h0, g_hex}, {4'h0, e_hex});
                chk($sformatf("den%0d", i), {6'h0, g_den}, {6'h0, e_den});
                chk($sformatf("fs%0d", i), {7'h0, g_fs}, {7'h0, e_fs});
            end
            chk($sformatf("pend%0d", i), {7'h0, g_pend}, {7'h0, m_pend[i]});
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_load(input logic [7:0] v);
        value = v;
        load  = 1'b1;
        cycle();
        load  = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_hex0"}, {4'h0, hex0}, 8'h00);
        chk({tag, "_den0"}, {6'h0, den0}, 8'h00);
        chk({tag, "_pend0"}, {7'h0, pend0}, 8'h00);
        chk({tag, "_fs0"}, {7'h0, fs0}, 8'h00);
        chk({tag, "_hex1"}, {4'h0, hex1}, 8'h00);
        chk({tag, "_den1"}, {6'h0, den1}, 8'h00);
        chk({tag, "_pend1"}, {7'h0, pend1}, 8'h00);
        chk({tag, "_fs1"}, {7'h0, fs1}, 8'h00);
    endtask

    initial begin
        // Power-up reset, released between edges.
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        reset_model();
        rst_n = 1'b1;
        check_all();
        run(26);

        // Mid-frame load of 0x3C, then watch it appear at the next frame.
        run(3);
        do_load(8'h3C);
        run(30);

        // Load 0x12, then 0x34 exactly on the gapped instance's wrap cycle.
        do_load(8'h12);
        for (int k = 0; k < 12; k++) begin
            if ((t % 12) == 11) break;
            cycle();
        end
        do_load(8'h34);
        run(26);

        // Digits forced dark for three frames; a load still transfers.
        en = 1'b0;
        run(5);
        do_load(8'hA7);
        run(30);
        en = 1'b1;
        run(14);

        // Leading-zero cases.
        do_load(8'h05);
        run(26);
        do_load(8'h00);
        run(26);
        do_load(8'h90);
        run(26);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            value = 8'($urandom);
            load  = ($urandom_range(0, 5) == 0);
            en    = ($urandom_range(0, 7) != 0);
            cycle();
        end
        load = 1'b0;
        en   = 1'b1;

        // Asynchronous reset while the gapped instance is lighting a digit.
        do_load(8'h5A);
        for (int k = 0; k < 12; k++) begin
            if ((t % 6) >= 3) break;
            cycle();
        end
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        #1;
        reset_model();
        rst_n = 1'b1;
        check_all();
        run(30);

        for (int k = 0; k < 100; k++) begin
            value = 8'($urandom);
            load  = ($urandom_range(0, 3) == 0);
            cycle();
        end
        load = 1'b0;
        run(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
